add_station: RTL and testbench
==============================

# add_station

Reservation-station and execution block for the ADD functional unit, sitting on the far side of the dispatch/completion protocol. It accepts ADD instructions issued on the two 40-bit dispatch buses into slots A0/A1/A2, snoops the completion buses for pending operand tags, runs ready instructions through a single multi-cycle adder, and broadcasts `{tag, result}` on `addbus`. The dispatch unit uses `addbus` to release slots and clear register tags.

## Interface
- `DATA_W`, 32: operand/result width; completion bus is `{tag[7:0], data[DATA_W-1:0]}`.
- `ADD_LAT`, 2: adder latency in cycles, ≥1.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `instbus1`, `instbus2` in 40: dispatch buses; `[39:32]` station tag, `[31:24]` opcode, `[23:16]` op1 (register code or tag), `[15:8]` op2, `[7:0]` destination register.
- `instvld1`, `instvld2` in 1: bus carries a new instruction this cycle.
- `regvals` in 4*DATA_W: architectural R0..R3 values, R0 in the LSBs.
- `multbus`, `loadbus` in 40: other completion buses; tag 0 means idle.
- `addbus` out 40: registered ADD completion broadcast; tag 0 means idle.
- `dispatch_err` out 1: one-cycle pulse when a dispatch is dropped.

## Operation
- Accept when `instvldN=1`, tag ∈ {A0,A1,A2}, opcode ADD. Any other tag or opcode is ignored silently.
- A slot holds: busy, opcode, dest, and per operand either `(ready, value)` or `(pending, qtag)`.
- Operand resolution at accept:
  - Register code R0..R3: value comes from `regvals`; the operand is ready.
  - Anything else is a tag and is stored as pending.
- Snooping: every cycle, each pending operand compares its qtag with the tags on `addbus` (own output), `multbus` and `loadbus`.
  - On a match it captures the data field and becomes ready.
  - A tag equal to the incoming op tag at accept is captured in the same cycle.
- Issue:
  - When the adder is idle and at least one busy slot has both operands ready, select one round-robin, starting at the slot after the last issued (reset pointer = A0).
  - Latch op1+op2, wrapping modulo 2^DATA_W, and load the latency counter with ADD_LAT.
- Broadcast:
  - When the counter expires, `addbus <= {slot tag, sum}` for exactly one cycle, then `addbus <= 0`.
  - The slot is freed on the same edge that loads the broadcast.
- Error cases (`dispatch_err` pulses, state unchanged):
  - Dispatch to a slot that is busy and not being freed on this edge.
  - Both buses targeting the same tag in one cycle: instbus1 wins, instbus2 is dropped.

## Timing
- Reset values: `addbus=0`, `dispatch_err=0`, all slots free, adder idle, RR pointer A0.
- Reset mid-operation discards all slots and the in-flight add; no broadcast follows.
- Instruction accepted at edge N with both operands ready: earliest issue is edge N+1; `addbus` is valid after edge N+1+ADD_LAT.
- A new issue may occur on the same edge the broadcast is loaded. Sustained throughput is one add per ADD_LAT cycles.
- Wake-up: a broadcast visible during cycle C is captured at the end of C; the woken slot can issue on the next edge.
- A slot being freed may be re-dispatched on the same edge; free takes effect first, then the write.
- Both buses may accept into different slots in one cycle.
- Snooping and the adder keep running while all slots are full.

## Configuration
- `ADD_STATION_SUB_EN` defined:
  - Opcode SUB is also accepted.
  - Result is op1−op2 modulo 2^DATA_W; the slot opcode selects add or subtract at issue.
- Not defined:
  - SUB instructions are ignored like any unknown opcode.
  - No subtract datapath is built.

## Structure
- Shared package holds:
  - Station tags A0/A1/A2, M0/M1, LD0/LD1, ST0/ST1.
  - Register codes R0..R3.
  - Opcodes LOAD/STORE/ADD/MULTI/SUB.
  - Bus field positions.
  - Idle tag value 0.
- Sub-module `rs_slot`, instantiated three times: holds one entry, performs operand resolution and tag snooping, and produces `ready`.
- Top level contains the arbiter, the adder counter and the broadcast register.

## Test plan
- R1=5, R2=7; `instbus1` = A0, ADD, R1, R2, dest R3, at edge N → `addbus={A0,12}` after edge N+3 (ADD_LAT=2), idle the following cycle.
- A0 op1 = tag M0 (pending), then `multbus={M0,100}` → A0 issues the next edge and broadcasts `{A0,100+op2}`.
- A0 = R1+R2, A1 = A0+R1 on both buses in the same cycle → A1 wakes from its own `addbus` and broadcasts `{A1,17}`.
- A0/A1/A2 all ready together → broadcasts in order A0, A1, A2 at ADD_LAT spacing.
- 0xFFFFFFFF+1 → data field 0.
- Dispatch to busy A1 → `dispatch_err` pulse, A1 contents unchanged.
- `rst_n=0` during A2 execution → no A2 broadcast, `addbus=0`.

Source files
------------

// File: rtl/add_station_pkg.sv
// ---------------------------------------------------------------------------
// add_station_pkg
// Shared encodings for the ADD reservation station: station tags, register
// codes, opcodes, dispatch-bus field positions and small decode helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package add_station_pkg;

    // Station tags; tag 0 on a completion bus means the bus is idle.
    localparam logic [7:0] TAG_IDLE = 8'h00;
    localparam logic [7:0] TAG_A0   = 8'h10;
    localparam logic [7:0] TAG_A1   = 8'h11;
    localparam logic [7:0] TAG_A2   = 8'h12;
    localparam logic [7:0] TAG_M0   = 8'h20;
    localparam logic [7:0] TAG_M1   = 8'h21;
    localparam logic [7:0] TAG_LD0  = 8'h30;
    localparam logic [7:0] TAG_LD1  = 8'h31;
    localparam logic [7:0] TAG_ST0  = 8'h40;
    localparam logic [7:0] TAG_ST1  = 8'h41;

    // Architectural register codes as they appear in operand fields.
    localparam logic [7:0] REG_R0 = 8'h01;
    localparam logic [7:0] REG_R1 = 8'h02;
    localparam logic [7:0] REG_R2 = 8'h03;
    localparam logic [7:0] REG_R3 = 8'h04;

    typedef enum logic [7:0] {
        OP_LOAD  = 8'h01,
        OP_STORE = 8'h02,
        OP_ADD   = 8'h03,
        OP_MULTI = 8'h04,
        OP_SUB   = 8'h05
    } opcode_e;

    // Dispatch bus field positions (each field is 8 bits wide).
    localparam int FIELD_W       = 8;
    localparam int INST_W        = 40;
    localparam int INST_TAG_LSB  = 32;
    localparam int INST_OP_LSB   = 24;
    localparam int INST_SRC1_LSB = 16;
    localparam int INST_SRC2_LSB = 8;
    localparam int INST_DST_LSB  = 0;

    localparam int NUM_SLOTS = 3;

    function automatic logic is_reg_code(input logic [7:0] c);
        return (c >= REG_R0) && (c <= REG_R3);
    endfunction

    function automatic logic [1:0] reg_index(input logic [7:0] c);
        return 2'(c - REG_R0);
    endfunction

    function automatic logic is_rs_tag(input logic [7:0] t);
        return (t == TAG_A0) || (t == TAG_A1) || (t == TAG_A2);
    endfunction

    function automatic logic [1:0] tag_slot(input logic [7:0] t);
        return 2'(t - TAG_A0);
    endfunction

    function automatic logic [7:0] slot_tag(input logic [1:0] idx);
        logic [7:0] t;
        case (idx)
            2'd0:    t = TAG_A0;
            2'd1:    t = TAG_A1;
            2'd2:    t = TAG_A2;
            default: t = TAG_IDLE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/add_station_rs_slot.sv
// ---------------------------------------------------------------------------
// rs_slot
// One reservation-station entry. Resolves operands at accept (register code
// -> value from i_regvals, otherwise a pending tag, captured at once if that
// tag is on a completion bus this cycle) and snoops the completion buses
// every cycle to wake pending operands.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_wr                 load a new instruction this edge (wins over i_free)
//   i_free               entry is released this edge
//   i_op/i_src1/i_src2/i_dest  fields of the incoming instruction
//   i_regvals            R0..R3 values, R0 in the LSBs
//   i_addbus/i_multbus/i_loadbus  completion buses {tag, data}
//   o_busy, o_ready      entry occupied / occupied with both operands ready
//   o_op, o_dest, o_v1, o_v2  stored opcode, destination, operand values
// ---------------------------------------------------------------------------
module rs_slot
    import add_station_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr,
    input  logic                  i_free,
    input  logic [7:0]            i_op,
    input  logic [7:0]            i_src1,
    input  logic [7:0]            i_src2,
    input  logic [7:0]            i_dest,
    input  logic [4*DATA_W-1:0]   i_regvals,
    input  logic [DATA_W+7:0]     i_addbus,
    input  logic [DATA_W+7:0]     i_multbus,
    input  logic [DATA_W+7:0]     i_loadbus,
    output logic                  o_busy,
    output logic                  o_ready,
    output logic [7:0]            o_op,
    output logic [7:0]            o_dest,
    output logic [DATA_W-1:0]     o_v1,
    output logic [DATA_W-1:0]     o_v2
);

    logic              r_busy;
    logic [7:0]        r_op;
    logic [7:0]        r_dest;
    logic [7:0]        r_q1;
    logic [7:0]        r_q2;
    logic              r_rdy1;
    logic              r_rdy2;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;

    logic [DATA_W:0]   w_new1;
    logic [DATA_W:0]   w_new2;
    logic [DATA_W:0]   w_snp1;
    logic [DATA_W:0]   w_snp2;

    // {hit, data} for a tag against the three completion buses.
    function automatic logic [DATA_W:0] snoop(
        input logic [7:0]        q,
        input logic [DATA_W+7:0] ba,
        input logic [DATA_W+7:0] bm,
        input logic [DATA_W+7:0] bl
    );
        logic [DATA_W:0] r;
        if (q == TAG_IDLE) begin
            r = '0;
        end else if (q == ba[DATA_W +: 8]) begin
            r = {1'b1, ba[DATA_W-1:0]};
        end else if (q == bm[DATA_W +: 8]) begin
            r = {1'b1, bm[DATA_W-1:0]};
        end else if (q == bl[DATA_W +: 8]) begin
            r = {1'b1, bl[DATA_W-1:0]};
        end else begin
            r = '0;
        end
        return r;
    endfunction

    // {ready, value} for an operand code presented at accept.
    function automatic logic [DATA_W:0] resolve(
        input logic [7:0]          c,
        input logic [4*DATA_W-1:0] rv,
        input logic [DATA_W+7:0]   ba,
        input logic [DATA_W+7:0]   bm,
        input logic [DATA_W+7:0]   bl
    );
        logic [DATA_W:0] r;
        if (is_reg_code(c)) begin
            r = {1'b1, rv[int'(reg_index(c)) * DATA_W +: DATA_W]};
        end else begin
            r = snoop(c, ba, bm, bl);
        end
        return r;
    endfunction

    // Operand resolution for a new instruction and wake-up for stored tags.
    always_comb begin
        w_new1 = resolve(i_src1, i_regvals, i_addbus, i_multbus, i_loadbus);
        w_new2 = resolve(i_src2, i_regvals, i_addbus, i_multbus, i_loadbus);
        w_snp1 = snoop(r_q1, i_addbus, i_multbus, i_loadbus);
        w_snp2 = snoop(r_q2, i_addbus, i_multbus, i_loadbus);
    end

    // Entry state: a write replaces the entry even when it is freed on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_op   <= 8'h00;
            r_dest <= 8'h00;
            r_q1   <= 8'h00;
            r_q2   <= 8'h00;
            r_rdy1 <= 1'b0;
            r_rdy2 <= 1'b0;
            r_val1 <= '0;
            r_val2 <= '0;
        end else if (i_wr) begin
            r_busy <= 1'b1;
            r_op   <= i_op;
            r_dest <= i_dest;
            r_q1   <= i_src1;
            r_q2   <= i_src2;
            r_rdy1 <= w_new1[DATA_W];
            r_val1 <= w_new1[DATA_W-1:0];
            r_rdy2 <= w_new2[DATA_W];
            r_val2 <= w_new2[DATA_W-1:0];
        end else begin
            r_busy <= r_busy & ~i_free;
            if (!r_rdy1 && w_snp1[DATA_W]) begin
                r_rdy1 <= 1'b1;
                r_val1 <= w_snp1[DATA_W-1:0];
            end
            if (!r_rdy2 && w_snp2[DATA_W]) begin
                r_rdy2 <= 1'b1;
                r_val2 <= w_snp2[DATA_W-1:0];
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy & r_rdy1 & r_rdy2;
    assign o_op    = r_op;
    assign o_dest  = r_dest;
    assign o_v1    = r_val1;
    assign o_v2    = r_val2;

endmodule

// File: rtl/add_station.sv
// ---------------------------------------------------------------------------
// add_station
// ADD reservation station (slots A0/A1/A2) plus a single multi-cycle adder.
// Accepts ADD dispatches, snoops completion buses, issues ready entries
// round-robin and broadcasts {tag, result} on addbus for one cycle.
// Optional feature: define ADD_STATION_SUB_EN to also accept SUB (op1-op2).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   instbus1/2, instvld1/2 dispatch buses {tag, opcode, op1, op2, dest}
//   regvals                R0..R3 values, R0 in the LSBs
//   multbus, loadbus       other completion buses {tag, data}, tag 0 idle
//   addbus                 registered completion broadcast, tag 0 idle
//   dispatch_err           one-cycle pulse when a dispatch is dropped
// ---------------------------------------------------------------------------
module add_station
    import add_station_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [39:0]         instbus1,
    input  logic [39:0]         instbus2,
    input  logic                instvld1,
    input  logic                instvld2,
    input  logic [4*DATA_W-1:0] regvals,
    input  logic [DATA_W+7:0]   multbus,
    input  logic [DATA_W+7:0]   loadbus,
    output logic [DATA_W+7:0]   addbus,
    output logic                dispatch_err
);

    localparam int CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

    logic [DATA_W+7:0] r_addbus;
    logic              r_err;
    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_sel;
    logic [1:0]        r_rr;
    logic [DATA_W-1:0] r_sum;

    logic [7:0]        w_tag1;
    logic [7:0]        w_tag2;
    logic              w_v1;
    logic              w_v2;
    logic [1:0]        w_idx1;
    logic [1:0]        w_idx2;
    logic              w_same;
    logic              w_acc1;
    logic              w_acc2;
    logic              w_err;
    logic              w_expire;
    logic              w_issue;
    logic [2:0]        w_busy;
    logic [2:0]        w_ready;
    logic [2:0]        w_free;
    logic [2:0]        w_wr;
    logic [2:0]        w_cand;
    logic [3:0]        w_busy_eff;
    logic [1:0]        w_pick;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [7:0]        w_op_pick;
    logic [DATA_W-1:0] w_res;
    logic [7:0]        w_op   [NUM_SLOTS];
    logic [7:0]        w_dest [NUM_SLOTS];
    logic [DATA_W-1:0] w_sv1  [NUM_SLOTS];
    logic [DATA_W-1:0] w_sv2  [NUM_SLOTS];
    logic              w_unused;

    function automatic logic op_ok(input logic [7:0] op);
`ifdef ADD_STATION_SUB_EN
        return (op == OP_ADD) || (op == OP_SUB);
`else
        return (op == OP_ADD);
`endif
    endfunction

    // First candidate in the order f, s, t.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] cand,
        input logic [1:0] f,
        input logic [1:0] s,
        input logic [1:0] t
    );
        logic [1:0] p;
        if (cand[f]) begin
            p = f;
        end else if (cand[s]) begin
            p = s;
        end else begin
            p = t;
        end
        return p;
    endfunction

    // ---- dispatch decode -------------------------------------------------
    assign w_tag1 = instbus1[INST_TAG_LSB +: FIELD_W];
    assign w_tag2 = instbus2[INST_TAG_LSB +: FIELD_W];
    assign w_v1   = instvld1 && is_rs_tag(w_tag1) && op_ok(instbus1[INST_OP_LSB +: FIELD_W]);
    assign w_v2   = instvld2 && is_rs_tag(w_tag2) && op_ok(instbus2[INST_OP_LSB +: FIELD_W]);
    assign w_idx1 = tag_slot(w_tag1);
    assign w_idx2 = tag_slot(w_tag2);

    // A slot counts as busy only if it is not released on this edge.
    assign w_expire   = r_active && (r_cnt == CNT_W'(1));
    assign w_busy_eff = {1'b0, w_busy & ~w_free};
    assign w_same     = w_v1 && w_v2 && (w_idx1 == w_idx2);
    assign w_acc1     = w_v1 && !w_busy_eff[w_idx1];
    assign w_acc2     = w_v2 && !w_same && !w_busy_eff[w_idx2];
    assign w_err      = (w_v1 && !w_acc1) || (w_v2 && !w_acc2);

    // ---- slots -----------------------------------------------------------
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic [39:0] w_inst;
        assign w_free[g] = w_expire && (r_sel == 2'(g));
        assign w_wr[g]   = (w_acc1 && (w_idx1 == 2'(g))) || (w_acc2 && (w_idx2 == 2'(g)));
        assign w_inst    = (w_acc1 && (w_idx1 == 2'(g))) ? instbus1 : instbus2;

        rs_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr[g]),
            .i_free    (w_free[g]),
            .i_op      (w_inst[INST_OP_LSB   +: FIELD_W]),
            .i_src1    (w_inst[INST_SRC1_LSB +: FIELD_W]),
            .i_src2    (w_inst[INST_SRC2_LSB +: FIELD_W]),
            .i_dest    (w_inst[INST_DST_LSB  +: FIELD_W]),
            .i_regvals (regvals),
            .i_addbus  (r_addbus),
            .i_multbus (multbus),
            .i_loadbus (loadbus),
            .o_busy    (w_busy[g]),
            .o_ready   (w_ready[g]),
            .o_op      (w_op[g]),
            .o_dest    (w_dest[g]),
            .o_v1      (w_sv1[g]),
            .o_v2      (w_sv2[g])
        );
    end

    // ---- arbiter ---------------------------------------------------------
    // The slot finishing on this edge is excluded so it is never reissued.
    assign w_cand  = w_ready & ~w_free;
    assign w_issue = (!r_active || w_expire) && (|w_cand);

    // Round-robin pick starting at r_rr, then operand mux for the pick.
    always_comb begin
        case (r_rr)
            2'd1:    w_pick = rr_pick({1'b0, w_cand}, 2'd1, 2'd2, 2'd0);
            2'd2:    w_pick = rr_pick({1'b0, w_cand}, 2'd2, 2'd0, 2'd1);
            default: w_pick = rr_pick({1'b0, w_cand}, 2'd0, 2'd1, 2'd2);
        endcase
        case (w_pick)
            2'd1: begin
                w_a = w_sv1[1]; w_b = w_sv2[1]; w_op_pick = w_op[1];
            end
            2'd2: begin
                w_a = w_sv1[2]; w_b = w_sv2[2]; w_op_pick = w_op[2];
            end
            default: begin
                w_a = w_sv1[0]; w_b = w_sv2[0]; w_op_pick = w_op[0];
            end
        endcase
    end

    // Adder datapath: result computed at issue and held until broadcast.
    always_comb begin
`ifdef ADD_STATION_SUB_EN
        if (w_op_pick == OP_SUB) begin
            w_res = w_a - w_b;
        end else begin
            w_res = w_a + w_b;
        end
`else
        w_res = w_a + w_b;
`endif
    end

    // Destination and (without SUB) opcode are held but not needed here.
    assign w_unused = ^{w_dest[0], w_dest[1], w_dest[2], w_op_pick};

    // Adder counter, round-robin pointer, broadcast and error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addbus <= '0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_sel    <= 2'd0;
            r_rr     <= 2'd0;
            r_sum    <= '0;
        end else begin
            r_err <= w_err;
            if (w_expire) begin
                r_addbus <= {slot_tag(r_sel), r_sum};
            end else begin
                r_addbus <= '0;
            end
            if (w_issue) begin
                r_active <= 1'b1;
                r_cnt    <= CNT_W'(ADD_LAT);
                r_sel    <= w_pick;
                r_sum    <= w_res;
                r_rr     <= (w_pick == 2'd2) ? 2'd0 : w_pick + 2'd1;
            end else if (w_expire) begin
                r_active <= 1'b0;
            end else if (r_active) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign addbus       = r_addbus;
    assign dispatch_err = r_err;

endmodule

// File: tb/tb_add_station.sv
// ---------------------------------------------------------------------------
// tb_add_station
// Directed bench for add_station (DATA_W=32, ADD_LAT=2). Expected broadcasts
// are queued when the instruction is dispatched and popped by a monitor
// whenever addbus carries a non-idle tag; exact-cycle checks are made inline.
// ---------------------------------------------------------------------------
module tb_add_station;
    import add_station_pkg::*;

    localparam logic [31:0] R0V = 32'h0000_0001;
    localparam logic [31:0] R1V = 32'd5;
    localparam logic [31:0] R2V = 32'd7;
    localparam logic [31:0] R3V = 32'hFFFF_FFFF;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [39:0]   instbus1 = 40'h0;
    logic [39:0]   instbus2 = 40'h0;
    logic          instvld1 = 1'b0;
    logic          instvld2 = 1'b0;
    logic [127:0]  regvals  = {R3V, R2V, R1V, R0V};
    logic [39:0]   multbus  = 40'h0;
    logic [39:0]   loadbus  = 40'h0;
    logic [39:0]   addbus;
    logic          dispatch_err;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [39:0]   sb_q[$];

    add_station #(.DATA_W(32), .ADD_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instbus1     (instbus1),
        .instbus2     (instbus2),
        .instvld1     (instvld1),
        .instvld2     (instvld2),
        .regvals      (regvals),
        .multbus      (multbus),
        .loadbus      (loadbus),
        .addbus       (addbus),
        .dispatch_err (dispatch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [7:0] tag, input logic [7:0] op,
                                       input logic [7:0] s1, input logic [7:0] s2,
                                       input logic [7:0] d);
        return {tag, op, s1, s2, d};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard monitor: every non-idle broadcast must match the queue head.
    always @(negedge clk) begin
        if (addbus[39:32] != 8'h00) begin
            if (sb_q.size() == 0) check("sb_unexpected", addbus, 40'h0);
            else check("sb_bcast", addbus, sb_q.pop_front());
        end
    end

    initial begin
        // Reset
        ticks(2);
        check("rst_addbus", addbus, 40'h0);
        check("rst_err", {39'h0, dispatch_err}, 40'h0);
        rst_n = 1'b1;
        tick();

        // T1: R1+R2 into A0, broadcast after N+3
        instbus1 = mk(TAG_A0, OP_ADD, REG_R1, REG_R2, REG_R3);
        instvld1 = 1'b1;
        sb_q.push_back({TAG_A0, R1V + R2V});
        tick();                                   // edge N
        instvld1 = 1'b0;
        check("t1_err", {39'h0, dispatch_err}, 40'h0);
        ticks(2);                                 // N+2
        check("t1_early", addbus, 40'h0);
        tick();                                   // N+3
        check("t1_lat", addbus, {TAG_A0, 32'd12});
        tick();
        check("t1_idle", addbus, 40'h0);

        // T2: op1 pending on M0, woken by multbus
        instbus1 = mk(TAG_A0, OP_ADD, TAG_M0, REG_R2, REG_R3);
        instvld1 = 1'b1;
        sb_q.push_back({TAG_A0, 32'd100 + R2V});
        tick();
        instvld1 = 1'b0;
        ticks(4);
        check("t2_wait", addbus, 40'h0);
        multbus = {TAG_M0, 32'd100};
        tick();                                   // captured
        multbus = 40'h0;
        ticks(3);                                 // issue + ADD_LAT
        check("t2_wake", addbus, {TAG_A0, 32'd107});
        tick();

        // T3: A1 depends on A0 through addbus, both dispatched together
        instbus1 = mk(TAG_A0, OP_ADD, REG_R1, REG_R2, REG_R3);
        instbus2 = mk(TAG_A1, OP_ADD, TAG_A0, REG_R1, REG_R0);
        instvld1 = 1'b1;
        instvld2 = 1'b1;
        sb_q.push_back({TAG_A0, R1V + R2V});
        sb_q.push_back({TAG_A1, R1V + R2V + R1V});
        tick();                                   // edge N
        instvld1 = 1'b0;
        instvld2 = 1'b0;
        check("t3_err", {39'h0, dispatch_err}, 40'h0);
        ticks(7);                                 // N+7
        check("t3_chain", addbus, {TAG_A1, 32'd17});
        ticks(2);

        // Reset, then T4/T6: three slots woken together, error cases on the way
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_rst", addbus, 40'h0);
        instbus1 = mk(TAG_A0, OP_ADD, TAG_M1, REG_R1, REG_R3);
        instbus2 = mk(TAG_A1, OP_ADD, TAG_M1, REG_R2, REG_R3);
        instvld1 = 1'b1;
        instvld2 = 1'b1;
        tick();                                   // E1
        instbus1 = mk(TAG_A2, OP_ADD, TAG_M1, REG_R0, REG_R3);
        instbus2 = mk(TAG_A2, OP_ADD, REG_R1, REG_R1, REG_R3);
        tick();                                   // E2: same-tag collision
        check("t4_same_tag_err", {39'h0, dispatch_err}, 40'h1);
        instbus1 = mk(TAG_A1, OP_ADD, REG_R3, REG_R3, REG_R3);
        instvld2 = 1'b0;
        tick();                                   // E3: A1 busy
        check("t6_busy_err", {39'h0, dispatch_err}, 40'h1);
        instvld1 = 1'b0;
        multbus  = {TAG_M1, 32'd10};
        sb_q.push_back({TAG_A0, 32'd10 + R1V});
        sb_q.push_back({TAG_A1, 32'd10 + R2V});
        sb_q.push_back({TAG_A2, 32'd10 + R0V});
        tick();                                   // E4: wake all
        multbus = 40'h0;
        check("t4_err_clear", {39'h0, dispatch_err}, 40'h0);
        ticks(2);                                 // E6
        check("t4_e6_idle", addbus, 40'h0);
        tick();                                   // E7
        check("t4_a0", addbus, {TAG_A0, 32'd15});
        tick();                                   // E8
        check("t4_gap", addbus, 40'h0);
        tick();                                   // E9
        check("t4_a1", addbus, {TAG_A1, 32'd17});
        ticks(2);                                 // E11
        check("t4_a2", addbus, {TAG_A2, 32'd11});
        ticks(2);

        // T5: wrap-around
        instbus1 = mk(TAG_A0, OP_ADD, REG_R3, REG_R0, REG_R1);
        instvld1 = 1'b1;
        sb_q.push_back({TAG_A0, 32'h0});
        tick();
        instvld1 = 1'b0;
        ticks(3);
        check("t5_wrap", addbus, {TAG_A0, 32'h0});
        ticks(2);

        // T7: reset while A2 is executing
        instbus1 = mk(TAG_A2, OP_ADD, REG_R1, REG_R2, REG_R3);
        instvld1 = 1'b1;
        tick();                                   // accept
        instvld1 = 1'b0;
        tick();                                   // issue
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_rst", addbus, 40'h0);
        ticks(3);
        check("t7_no_bcast", addbus, 40'h0);

        // Station usable after reset
        instbus1 = mk(TAG_A1, OP_ADD, REG_R1, REG_R1, REG_R0);
        instvld1 = 1'b1;
        sb_q.push_back({TAG_A1, R1V + R1V});
        tick();
        instvld1 = 1'b0;

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        ticks(2);
        check("sb_drain", 40'(sb_q.size()), 40'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
